// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider answering the EX-stage divide handshake.
// Returns {remainder, quotient} for DIV/DIVU after 32 iterations plus a sign-fix cycle.
module div_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        END    = 2'd3
    } state_t;

    state_t      state;
    logic [64:0] work;
    logic [31:0] divisor;
    logic [5:0]  cnt;
    logic        sign_mode;
    logic        sign1;
    logic        sign2;

    logic [31:0] abs1;
    logic [31:0] abs2;
    logic [32:0] trial;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    // Magnitudes are taken from the live inputs; they only matter on the load edge.
    assign abs1 = (signed_div_i && opdata1_i[31]) ? -opdata1_i : opdata1_i;
    assign abs2 = (signed_div_i && opdata2_i[31]) ? -opdata2_i : opdata2_i;

    // A borrow out of bit 32 means the divisor does not fit: shift in a 0 instead.
    assign trial = {1'b0, work[63:32]} - {1'b0, divisor};

    // Sign fix uses the signs captured at load time, not the current operand inputs.
    assign quot_fix = (sign_mode && (sign1 ^ sign2)) ? -work[31:0]  : work[31:0];
    assign rem_fix  = (sign_mode && sign1)           ? -work[64:33] : work[64:33];

    // NOTE: every register here is written with <= so all state updates on an
    // edge see the pre-edge values of each other, matching the flop hardware.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FREE;
            work      <= '0;
            divisor   <= '0;
            cnt       <= '0;
            sign_mode <= 1'b0;
            sign1     <= 1'b0;
            sign2     <= 1'b0;
            result_o  <= '0;
            ready_o   <= 1'b0;
        end else begin
            case (state)
                FREE: begin
                    result_o <= '0;
                    ready_o  <= 1'b0;
                    if (start_i && !annul_i) begin
                        if (opdata2_i == 32'd0) begin
                            state <= BYZERO;
                        end else begin
                            state     <= ON;
                            cnt       <= '0;
                            work      <= {32'b0, abs1, 1'b0};
                            divisor   <= abs2;
                            sign_mode <= signed_div_i;
                            sign1     <= opdata1_i[31];
                            sign2     <= opdata2_i[31];
                        end
                    end
                end

                BYZERO: begin
                    work     <= '0;
                    result_o <= '0;
                    ready_o  <= 1'b1;
                    state    <= END;
                end

                ON: begin
                    if (annul_i) begin
                        state    <= FREE;
                        cnt      <= '0;
                        result_o <= '0;
                        ready_o  <= 1'b0;
                    end else if (cnt < 6'd32) begin
                        if (trial[32]) begin
                            work <= {work[63:0], 1'b0};
                        end else begin
                            work <= {trial[31:0], work[31:0], 1'b1};
                        end
                        cnt <= cnt + 6'd1;
                    end else begin
                        result_o <= {rem_fix, quot_fix};
                        ready_o  <= 1'b1;
                        cnt      <= '0;
                        state    <= END;
                    end
                end

                END: begin
                    // Result is held until EX drops start; annul has no effect here.
                    if (!start_i) begin
                        result_o <= '0;
                        ready_o  <= 1'b0;
                        state    <= FREE;
                    end
                end

                default: begin
                    state <= FREE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed handshake scenarios plus randomized
// divides compared against a plain-arithmetic reference model.
module tb_div_seq;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int total = 0;
    int bad   = 0;

    div_seq dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: 64-bit integer division truncates toward zero and the remainder
    // takes the dividend's sign; divide by zero yields 0/0.
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        if (y == 32'd0) return 64'd0;
        if (sgn) begin
            sx = $signed(x);
            sy = $signed(y);
        end else begin
            sx = {32'b0, x};
            sy = {32'b0, y};
        end
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
    endfunction

    // Drives one request with start held, scrambles the operand inputs after the
    // load edge, and reports the edge count at which ready_o was first seen.
    task automatic do_div(input logic sgn, input logic [31:0] x, input logic [31:0] y,
                          output logic [63:0] res, output int lat);
        signed_div_i = sgn;
        opdata1_i    = x;
        opdata2_i    = y;
        start_i      = 1'b1;
        lat          = -1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) begin
                opdata1_i = $urandom;
                opdata2_i = $urandom;
            end
            if (ready_o) begin
                lat = n;
                break;
            end
        end
        res = result_o;
    endtask

    task automatic drop_start(input string name);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            bad++;
            $display("FAIL %s drop: ready=%b result=%h, want ready=0 result=0", name, ready_o, result_o);
        end
    endtask

    task automatic run_case(input string name, input logic sgn, input logic [31:0] x,
                            input logic [31:0] y, input logic [63:0] want_res, input int want_lat);
        logic [63:0] res;
        int          lat;
        do_div(sgn, x, y, res, lat);
        total++;
        if (lat !== want_lat) begin
            bad++;
            $display("FAIL %s latency: got %0d edges, want %0d", name, lat, want_lat);
        end
        total++;
        if (res !== want_res) begin
            bad++;
            $display("FAIL %s result: got %h, want %h", name, res, want_res);
        end
        drop_start(name);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        total++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            bad++;
            $display("FAIL reset: ready=%b result=%h, want 0/0", ready_o, result_o);
        end
    endtask

    task automatic test_unsigned();
        run_case("u100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 34);
        run_case("u_big", 1'b0, 32'hFFFFFFFF, 32'h00000003, ref_div(1'b0, 32'hFFFFFFFF, 32'h3), 34);
    endtask

    task automatic test_signed();
        run_case("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 34);
        run_case("u_m7_2", 1'b0, 32'hFFFFFFF9, 32'd2, 64'h00000001_7FFFFFFC, 34);
        run_case("s_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 34);
        run_case("s_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 34);
        run_case("s_m7_m2", 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, ref_div(1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE), 34);
    endtask

    task automatic test_div_zero();
        run_case("s_zero", 1'b1, 32'h80001234, 32'd0, 64'd0, 2);
        run_case("u_zero", 1'b0, 32'hDEADBEEF, 32'd0, 64'd0, 2);
    endtask

    task automatic test_annul();
        int seen;
        signed_div_i = 1'b0;
        opdata1_i    = 32'h12345678;
        opdata2_i    = 32'h00000013;
        start_i      = 1'b1;
        annul_i      = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        annul_i = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            bad++;
            $display("FAIL annul_on: ready=%b result=%h, want 0/0", ready_o, result_o);
        end
        // start and annul together in FREE must never launch a divide
        seen = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (ready_o) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL annul_free: ready seen %0d cycles, want 0", seen);
        end
        annul_i = 1'b0;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        run_case("after_annul", 1'b0, 32'hFFFFFFFF, 32'h00000010, 64'h0000000F_0FFFFFFF, 34);
    endtask

    task automatic test_annul_in_end();
        logic [63:0] res;
        int          lat;
        do_div(1'b0, 32'd1000, 32'd33, res, lat);
        annul_i = 1'b1;
        @(posedge clk);
        #1;
        annul_i = 1'b0;
        total++;
        if (ready_o !== 1'b1 || result_o !== ref_div(1'b0, 32'd1000, 32'd33)) begin
            bad++;
            $display("FAIL end_hold: ready=%b result=%h, want 1/%h", ready_o, result_o,
                     ref_div(1'b0, 32'd1000, 32'd33));
        end
        drop_start("end_hold");
    endtask

    task automatic test_reset_mid();
        logic [63:0] res;
        int          lat;
        int          seen;
        signed_div_i = 1'b0;
        opdata1_i    = 32'h0000FFFF;
        opdata2_i    = 32'h00000005;
        start_i      = 1'b1;
        repeat (21) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        start_i = 1'b0;
        total++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            bad++;
            $display("FAIL reset_mid: ready=%b result=%h, want 0/0", ready_o, result_o);
        end
        seen = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (ready_o) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL reset_mid_stale: ready seen %0d cycles, want 0", seen);
        end

        // start dropped during ON: divide still completes with a one-cycle pulse
        signed_div_i = 1'b1;
        opdata1_i    = 32'hFFFF0000;
        opdata2_i    = 32'h00000007;
        start_i      = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        start_i = 1'b0;
        lat     = 5;
        for (int n = 6; n <= 60; n++) begin
            @(posedge clk);
            #1;
            if (ready_o) begin
                lat = n;
                break;
            end
        end
        res = result_o;
        total++;
        if (lat !== 34 || res !== ref_div(1'b1, 32'hFFFF0000, 32'h7)) begin
            bad++;
            $display("FAIL drop_mid: lat=%0d result=%h, want 34/%h", lat, res,
                     ref_div(1'b1, 32'hFFFF0000, 32'h7));
        end
        @(posedge clk);
        #1;
        total++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            bad++;
            $display("FAIL drop_mid_pulse: ready=%b result=%h, want 0/0", ready_o, result_o);
        end
    endtask

    task automatic test_back_to_back();
        // drop_start leaves us one edge after END->FREE; the next start is immediate
        run_case("b2b_a", 1'b0, 32'd123456, 32'd789, ref_div(1'b0, 32'd123456, 32'd789), 34);
        run_case("b2b_b", 1'b1, 32'hFFFFFC00, 32'd10, ref_div(1'b1, 32'hFFFFFC00, 32'd10), 34);
    endtask

    task automatic test_random();
        logic [31:0] x, y;
        logic        sgn;
        logic [63:0] res;
        int          lat;
        for (int i = 0; i < 40; i++) begin
            sgn = 1'($urandom);
            x   = $urandom;
            case ($urandom_range(0, 4))
                0:       y = 32'd0;
                1:       y = $urandom_range(1, 15);
                2:       y = -$urandom_range(1, 15);
                default: y = $urandom;
            endcase
            do_div(sgn, x, y, res, lat);
            total++;
            if (lat !== ((y == 32'd0) ? 2 : 34) || res !== ref_div(sgn, x, y)) begin
                bad++;
                $display("FAIL rand%0d: sgn=%b %h/%h lat=%0d result=%h, want %h", i, sgn, x, y,
                         lat, res, ref_div(sgn, x, y));
            end
            drop_start("rand");
        end
    endtask

    initial begin
        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_annul();
        test_annul_in_end();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
